// File: rtl/fp_pkg.sv
// Shared types and constants for the front-panel I/O engine:
// button FSM state encoding, 7-segment font and a small sizing helper.
package fp_pkg;

    typedef enum logic [2:0] {
        LOCK,
        IDLE,
        PWAIT,
        FIRE,
        HELD,
        FIRE_R,
        RWAIT
    } btn_state_t;

    // Cathode patterns {g..a}, active low; octal digits use entries 0-7
    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fp_panel_io_if.sv
// Board-pin side bundle of the front panel: raw buttons/switches and display data in,
// conditioned button/switch signals and multiplexed 7-segment drive out.
interface fp_panel_io_if #(
    parameter int NUM_BTN    = 5,
    parameter int SW_W       = 13,
    parameter int DIGITS     = 4,
    parameter int DIGIT_BITS = 3
);

    logic [NUM_BTN-1:0]           btn_raw;
    logic [NUM_BTN-1:0]           btn_pulse;
    logic [NUM_BTN-1:0]           btn_level;
    logic [SW_W-1:0]              sw_raw;
    logic [SW_W-1:0]              sw_sync;
    logic [DIGITS*DIGIT_BITS-1:0] disp_value;
    logic [DIGITS-1:0]            dp_mask;
    logic                         blank_lead;
    logic [DIGITS-1:0]            an;
    logic [6:0]                   seg;
    logic                         dp;

    modport master (
        output btn_raw, sw_raw, disp_value, dp_mask, blank_lead,
        input  btn_pulse, btn_level, sw_sync, an, seg, dp
    );

    modport slave (
        input  btn_raw, sw_raw, disp_value, dp_mask, blank_lead,
        output btn_pulse, btn_level, sw_sync, an, seg, dp
    );

endinterface

// File: rtl/fp_debounce.sv
// One push-button conditioner: debounce with reset lockout, one-shot press pulse,
// optional auto-repeat while held, and a debounced level output.
module fp_debounce
    import fp_pkg::*;
#(
    parameter int DEB_CYC    = 5,
    parameter bit REPEAT_EN  = 1'b0,
    parameter int REPEAT_DLY = 20,
    parameter int REPEAT_PER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic s2_i,
    output logic pulse_o,
    output logic level_o
);

    localparam int CMAX = max3(DEB_CYC, REPEAT_DLY, REPEAT_PER);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DEB_LD = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] DLY_LD = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] PER_LD = CW'(REPEAT_PER - 1);

    btn_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;
    logic          level_q;

    // Outputs are registered alongside the state so they line up with it exactly
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LOCK;
            cnt_q   <= DEB_LD;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                LOCK: begin
                    if (s2_i) begin
                        cnt_q <= DEB_LD;
                    end else if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                IDLE: begin
                    if (s2_i) begin
                        state_q <= PWAIT;
                        cnt_q   <= DEB_LD;
                    end
                end
                PWAIT: begin
                    if (!s2_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= FIRE;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIRE: begin
                    state_q <= HELD;
                    cnt_q   <= DLY_LD;
                end
                HELD: begin
                    // Without repeat the timer just parks at zero
                    if (!s2_i) begin
                        state_q <= RWAIT;
                        cnt_q   <= DEB_LD;
                    end else if (REPEAT_EN && cnt_q == '0) begin
                        state_q <= FIRE_R;
                        pulse_q <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIRE_R: begin
                    state_q <= HELD;
                    cnt_q   <= PER_LD;
                end
                RWAIT: begin
                    if (s2_i) begin
                        state_q <= HELD;
                        cnt_q   <= PER_LD;
                    end else if (cnt_q == '0) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= LOCK;
                    cnt_q   <= DEB_LD;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/fp_panel_io.sv
// Front-panel I/O engine: synchronises switches and buttons, conditions each button,
// and scans a frame-latched value onto a multiplexed 7-segment display.
module fp_panel_io
    import fp_pkg::*;
#(
    parameter int                 NUM_BTN     = 5,
    parameter int                 SW_W        = 13,
    parameter int                 DIGITS      = 4,
    parameter int                 DIGIT_BITS  = 3,
    parameter int                 DEB_CYC     = 5,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = '0,
    parameter int                 REPEAT_DLY  = 20,
    parameter int                 REPEAT_PER  = 8,
    parameter int                 SCAN_DIV    = 4
) (
    input logic          clock,
    input logic          reset,
    fp_panel_io_if.slave bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = DIGITS * DIGIT_BITS;

    logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
    logic [NUM_BTN-1:0] btn_pulse, btn_level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= bus.btn_raw;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= bus.sw_raw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    assign bus.sw_sync = sw_s2_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        fp_debounce #(
            .DEB_CYC    (DEB_CYC),
            .REPEAT_EN  (REPEAT_MASK[g]),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_deb (
            .clock   (clock),
            .reset   (reset),
            .s2_i    (btn_s2_q[g]),
            .pulse_o (btn_pulse[g]),
            .level_o (btn_level[g])
        );
    end

    assign bus.btn_pulse = btn_pulse;
    assign bus.btn_level = btn_level;

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              loaded_q;
    logic [VW-1:0]     frame_val_q, frame_val_d;
    logic [DIGITS-1:0] frame_dp_q, frame_dp_d;
    logic              frame_blank_q, frame_blank_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              load;
    logic [3:0]        digit;
    logic              higher_nz;
    logic              dp_bit;

    // Drive outputs from next-state slot and frame so the display matches idx_q
    always_comb begin
        pre_d         = pre_q;
        idx_d         = idx_q;
        frame_val_d   = frame_val_q;
        frame_dp_d    = frame_dp_q;
        frame_blank_d = frame_blank_q;
        load          = !loaded_q;
        digit         = '0;
        higher_nz     = 1'b0;
        dp_bit        = 1'b0;

        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d = '0;
                load  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end

        if (load) begin
            frame_val_d   = bus.disp_value;
            frame_dp_d    = bus.dp_mask;
            frame_blank_d = bus.blank_lead;
        end

        for (int j = 0; j < DIGITS; j++) begin
            if (j == int'(idx_d)) begin
                digit[DIGIT_BITS-1:0] = frame_val_d[j*DIGIT_BITS +: DIGIT_BITS];
                dp_bit                = frame_dp_d[j];
            end
            if (j >= int'(idx_d) && frame_val_d[j*DIGIT_BITS +: DIGIT_BITS] != '0) begin
                higher_nz = 1'b1;
            end
        end

        an_d = ~(DIGITS'(1) << idx_d);
        dp_d = ~dp_bit;
        if (frame_blank_d && idx_d != '0 && !higher_nz) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = SEG_FONT[digit];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q         <= '0;
            idx_q         <= '0;
            loaded_q      <= 1'b0;
            frame_val_q   <= '0;
            frame_dp_q    <= '0;
            frame_blank_q <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            loaded_q      <= 1'b1;
            frame_val_q   <= frame_val_d;
            frame_dp_q    <= frame_dp_d;
            frame_blank_q <= frame_blank_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_fp_panel_io.sv
// Directed bench for fp_panel_io: reset state, scanning/blanking/frame latch,
// switch sync, press latency, bounce rejection, auto-repeat, reset lockout, simultaneous presses.
module tb_fp_panel_io;

    localparam int NUM_BTN    = 5;
    localparam int SW_W       = 13;
    localparam int DIGITS     = 4;
    localparam int DIGIT_BITS = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fp_panel_io_if #(
        .NUM_BTN    (NUM_BTN),
        .SW_W       (SW_W),
        .DIGITS     (DIGITS),
        .DIGIT_BITS (DIGIT_BITS)
    ) bus ();

    fp_panel_io #(
        .NUM_BTN     (NUM_BTN),
        .SW_W        (SW_W),
        .DIGITS      (DIGITS),
        .DIGIT_BITS  (DIGIT_BITS),
        .DEB_CYC     (5),
        .REPEAT_MASK (5'b00100),
        .REPEAT_DLY  (20),
        .REPEAT_PER  (8),
        .SCAN_DIV    (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulseCnt [NUM_BTN];
    int pulse2Cyc [$];

    // Pulse bookkeeping on the falling edge, well away from the active edge
    always @(negedge clock) begin
        cyc = cyc + 1;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (bus.btn_pulse[i]) begin
                pulseCnt[i] = pulseCnt[i] + 1;
                if (i == 2) pulse2Cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_BTN-1:0] btn, input int n);
        bus.btn_raw = btn;
        tick(n);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    int base0, base1, base2, qs;

    initial begin
        bus.btn_raw    = '0;
        bus.sw_raw     = '0;
        bus.disp_value = 12'o0705;
        bus.dp_mask    = 4'b1000;
        bus.blank_lead = 1'b1;
        tick(3);
        checkOutput("rst_an", 32'(bus.an), 32'hF);
        checkOutput("rst_seg", 32'(bus.seg), 32'h7F);
        checkOutput("rst_dp", 32'(bus.dp), 32'h1);
        checkOutput("rst_pulse", 32'(bus.btn_pulse), 32'h0);
        checkOutput("rst_level", 32'(bus.btn_level), 32'h0);
        checkOutput("rst_sw", 32'(bus.sw_sync), 32'h0);

        $display("[TB] scanner");
        reset = 1'b0;
        tick(1);
        checkOutput("scan0_an", 32'(bus.an), 32'hE);
        checkOutput("scan0_seg", 32'(bus.seg), 32'h12);
        checkOutput("scan0_dp", 32'(bus.dp), 32'h1);
        tick(2);
        checkOutput("scan0_hold_an", 32'(bus.an), 32'hE);
        tick(1);
        checkOutput("scan1_an", 32'(bus.an), 32'hD);
        checkOutput("scan1_seg", 32'(bus.seg), 32'h40);
        bus.disp_value = 12'o1234;
        bus.dp_mask    = 4'b0000;
        tick(4);
        checkOutput("scan2_an", 32'(bus.an), 32'hB);
        checkOutput("scan2_seg", 32'(bus.seg), 32'h78);
        checkOutput("scan2_dp", 32'(bus.dp), 32'h1);
        tick(4);
        checkOutput("scan3_an", 32'(bus.an), 32'h7);
        checkOutput("scan3_seg_blank", 32'(bus.seg), 32'h7F);
        checkOutput("scan3_dp", 32'(bus.dp), 32'h0);
        tick(4);
        checkOutput("frame2_d0_an", 32'(bus.an), 32'hE);
        checkOutput("frame2_d0_seg", 32'(bus.seg), 32'h19);
        tick(12);
        checkOutput("frame2_d3_an", 32'(bus.an), 32'h7);
        checkOutput("frame2_d3_seg", 32'(bus.seg), 32'h79);
        checkOutput("frame2_d3_dp", 32'(bus.dp), 32'h1);

        $display("[TB] switch sync");
        bus.sw_raw = 13'h1ABC;
        tick(1);
        checkOutput("sw_one_flop", 32'(bus.sw_sync), 32'h0);
        tick(1);
        checkOutput("sw_two_flop", 32'(bus.sw_sync), 32'h1ABC);

        $display("[TB] clean press");
        base0 = pulseCnt[0];
        applyStimulus(5'b00001, 7);
        checkOutput("press_early", 32'(bus.btn_pulse), 32'h0);
        tick(1);
        checkOutput("press_pulse", 32'(bus.btn_pulse), 32'h01);
        checkOutput("press_level", 32'(bus.btn_level), 32'h01);
        tick(1);
        checkOutput("press_one_shot", 32'(bus.btn_pulse), 32'h0);
        applyStimulus(5'b00000, 12);
        checkOutput("press_release_level", 32'(bus.btn_level), 32'h0);
        checkOutput("press_count", 32'(pulseCnt[0] - base0), 32'd1);

        $display("[TB] bounce");
        base2 = pulseCnt[2];
        applyStimulus(5'b00100, 3);
        applyStimulus(5'b00000, 2);
        applyStimulus(5'b00100, 7);
        checkOutput("bounce_no_pulse", 32'(pulseCnt[2] - base2), 32'd0);
        tick(1);
        checkOutput("bounce_pulse", 32'(bus.btn_pulse), 32'h04);
        applyStimulus(5'b00000, 15);
        checkOutput("bounce_count", 32'(pulseCnt[2] - base2), 32'd1);
        checkOutput("bounce_level", 32'(bus.btn_level), 32'h0);

        $display("[TB] auto-repeat");
        base0 = pulseCnt[0];
        base2 = pulseCnt[2];
        qs    = pulse2Cyc.size();
        applyStimulus(5'b00101, 60);
        checkOutput("repeat_level_held", 32'(bus.btn_level), 32'h05);
        applyStimulus(5'b00000, 20);
        checkOutput("repeat_count_b2", 32'(pulseCnt[2] - base2), 32'd5);
        checkOutput("repeat_count_b0", 32'(pulseCnt[0] - base0), 32'd1);
        checkOutput("repeat_level_off", 32'(bus.btn_level), 32'h0);
        if (pulse2Cyc.size() >= qs + 5) begin
            checkOutput("repeat_first_gap", 32'(pulse2Cyc[qs+1] - pulse2Cyc[qs]), 32'd21);
            checkOutput("repeat_period", 32'(pulse2Cyc[qs+2] - pulse2Cyc[qs+1]), 32'd9);
            checkOutput("repeat_period_last", 32'(pulse2Cyc[qs+4] - pulse2Cyc[qs+3]), 32'd9);
        end

        $display("[TB] reset lockout");
        applyStimulus(5'b00010, 2);
        reset = 1'b1;
        tick(2);
        checkOutput("lock_rst_pulse", 32'(bus.btn_pulse), 32'h0);
        reset = 1'b0;
        base1 = pulseCnt[1];
        applyStimulus(5'b00010, 50);
        checkOutput("lock_no_pulse", 32'(pulseCnt[1] - base1), 32'd0);
        checkOutput("lock_no_level", 32'(bus.btn_level), 32'h0);
        applyStimulus(5'b00000, 7);
        applyStimulus(5'b00010, 7);
        checkOutput("lock_repress_early", 32'(bus.btn_pulse), 32'h0);
        tick(1);
        checkOutput("lock_repress_pulse", 32'(bus.btn_pulse), 32'h02);
        applyStimulus(5'b00000, 12);

        $display("[TB] simultaneous");
        applyStimulus(5'b11111, 8);
        checkOutput("all_pulse", 32'(bus.btn_pulse), 32'h1F);
        tick(1);
        checkOutput("all_pulse_end", 32'(bus.btn_pulse), 32'h0);
        checkOutput("all_level", 32'(bus.btn_level), 32'h1F);
        applyStimulus(5'b00000, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
